// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command/response controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_cmd_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_GET_CMD,
      S_GET_ADDR,
      S_GET_DATA,
      S_GET_CHK,
      S_EXEC,
      S_RD_WAIT,
      S_SEND,
      S_TX_GUARD,
      S_TX_WAIT
   } state_t;

   localparam logic [7:0] CMD_WR        = 8'h57;
   localparam logic [7:0] CMD_RD        = 8'h52;

   localparam logic [7:0] STATUS_OK     = 8'h00;
   localparam logic [7:0] STATUS_CHKERR = 8'h01;
   localparam logic [7:0] STATUS_BADCMD = 8'h02;
   localparam logic [7:0] STATUS_RXERR  = 8'h03;

   // Frame checksum covers every byte between SYNC and CHK.
   function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
      return cmd ^ addr ^ data;
   endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Loadable down-counter; pulses timeout LOAD_VAL enabled cycles after the last load.
// Latency: timeout is combinational from the count register.
// Backpressure: none; load always wins over counting.
module uart_cmd_timer #(
   parameter int unsigned LOAD_VAL = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic timeout
);

   localparam int W = $clog2(LOAD_VAL + 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Reload on demand, otherwise count down while enabled and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = W'(LOAD_VAL);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign timeout = en && !load && (cnt_q == W'(1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses 5-byte SYNC/CMD/ADDR/DATA/CHK frames, runs one register access, sends SYNC/STATUS/RDATA.
// Latency: reg_wr 1 cycle after CHK; first tx_start 2 (write) or 3 (read) cycles after CHK.
// Backpressure: each response byte waits for tx_busy low; bytes arriving while busy are dropped and counted.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned TIMEOUT_MS = 10,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       rx_error,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic [7:0] drop_cnt
);

   localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;

   state_t     state_q, state_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic [7:0] chk_q, chk_d;
   logic [7:0] status_q, status_d;
   logic [7:0] rdata_q, rdata_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] drop_q, drop_d;
   logic [7:0] resp_byte;

   logic in_get, in_drop, byte_ok, tmr_load, tmr_timeout;

   // Timer control is derived straight from registered state so the timeout never loops back through the FSM logic.
   assign in_get   = (state_q == S_GET_CMD) || (state_q == S_GET_ADDR) ||
                     (state_q == S_GET_DATA) || (state_q == S_GET_CHK);
   assign in_drop  = (state_q == S_EXEC) || (state_q == S_RD_WAIT) || (state_q == S_SEND) ||
                     (state_q == S_TX_GUARD) || (state_q == S_TX_WAIT);
   assign byte_ok  = rx_done && !rx_error;
   assign tmr_load = byte_ok && (in_get || ((state_q == S_IDLE) && (rx_data == SYNC_BYTE)));

   uart_cmd_timer #(.LOAD_VAL(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .en      (in_get),
      .timeout (tmr_timeout)
   );

   // Response byte selected by the current send index.
   always_comb begin
      resp_byte = SYNC_BYTE;
      case (idx_q)
         2'd1:    resp_byte = status_q;
         2'd2:    resp_byte = rdata_q;
         default: resp_byte = SYNC_BYTE;
      endcase
   end

   // Frame parsing, execution and response sequencing.
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      data_d   = data_q;
      chk_d    = chk_q;
      status_d = status_q;
      rdata_d  = rdata_q;
      idx_d    = idx_q;
      drop_d   = drop_q;
      reg_wr   = 1'b0;
      reg_rd   = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;

      case (state_q)
         S_IDLE: begin
            idx_d = 2'd0;
            if (byte_ok && (rx_data == SYNC_BYTE)) begin
               status_d = STATUS_OK;
               rdata_d  = 8'h00;
               state_d  = S_GET_CMD;
            end
         end
         S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK: begin
            if (rx_error) begin
               status_d = STATUS_RXERR;
               rdata_d  = 8'h00;
               state_d  = S_SEND;
            end else if (rx_done) begin
               case (state_q)
                  S_GET_CMD:  begin cmd_d  = rx_data; state_d = S_GET_ADDR; end
                  S_GET_ADDR: begin addr_d = rx_data; state_d = S_GET_DATA; end
                  S_GET_DATA: begin data_d = rx_data; state_d = S_GET_CHK;  end
                  default:    begin chk_d  = rx_data; state_d = S_EXEC;     end
               endcase
            end else if (tmr_timeout) begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            state_d = S_SEND;
            rdata_d = 8'h00;
            if (chk_q != frame_chk(cmd_q, addr_q, data_q)) begin
               status_d = STATUS_CHKERR;
            end else if (cmd_q == CMD_WR) begin
               reg_wr   = 1'b1;
               status_d = STATUS_OK;
               rdata_d  = data_q;
            end else if (cmd_q == CMD_RD) begin
               reg_rd   = 1'b1;
               status_d = STATUS_OK;
               state_d  = S_RD_WAIT;
            end else begin
               status_d = STATUS_BADCMD;
            end
         end
         S_RD_WAIT: begin
            rdata_d = reg_rdata;
            state_d = S_SEND;
         end
         S_SEND: begin
            tx_data = resp_byte;
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = S_TX_GUARD;
            end
         end
         S_TX_GUARD: begin
            // The transmitter may not have raised tx_busy yet, so skip one cycle.
            tx_data = resp_byte;
            state_d = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            tx_data = resp_byte;
            if (!tx_busy) begin
               if (idx_q == 2'd2) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_SEND;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (rx_done && in_drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cmd_q    <= 8'h00;
         addr_q   <= 8'h00;
         data_q   <= 8'h00;
         chk_q    <= 8'h00;
         status_q <= 8'h00;
         rdata_q  <= 8'h00;
         idx_q    <= 2'd0;
         drop_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         chk_q    <= chk_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
         idx_q    <= idx_d;
         drop_q   <= drop_d;
      end
   end

   assign reg_addr  = addr_q;
   assign reg_wdata = data_q;
   assign busy      = (state_q != S_IDLE);
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a register-file model and a transmitter model.
// Latency: checks strobe and first-byte latency against the CHK byte.
// Backpressure: transmitter model holds tx_busy for tx_len cycles per byte.
module tb_uart_cmd_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_error;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata;
   logic       busy;
   logic [7:0] drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rx_cyc   = 0;
   int wr_cyc   = 0;
   int wr_cnt   = 0;
   int rd_cnt   = 0;
   int tx_len   = 4;
   logic [7:0] wr_addr, wr_data;
   logic [7:0] mem [256];
   logic [7:0] tx_q [$];
   int         start_cyc [$];

   uart_cmd_ctrl #(.CLK_FREQ(100_000), .TIMEOUT_MS(1), .SYNC_BYTE(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rx_error  (rx_error),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .busy      (busy),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Register file: writes land on the strobe, read data is presented for the next cycle.
   initial begin
      reg_rdata = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (reg_wr) begin
            mem[reg_addr] = reg_wdata;
            wr_addr = reg_addr;
            wr_data = reg_wdata;
            wr_cyc  = cyc;
            wr_cnt  = wr_cnt + 1;
         end
         if (reg_rd) begin
            reg_rdata = mem[reg_addr];
            rd_cnt    = rd_cnt + 1;
         end
      end
   end

   // Transmitter: capture each started byte and stay busy for tx_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            tx_q.push_back(tx_data);
            start_cyc.push_back(cyc);
            tx_busy = 1'b1;
            repeat (tx_len) @(negedge clk);
            tx_busy = 1'b0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      rx_cyc  = cyc;
      @(negedge clk);
      rx_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] k);
      send_byte(8'hA5);
      send_byte(c);
      send_byte(a);
      send_byte(d);
      send_byte(k);
   endtask

   task automatic clear_obs();
      tx_q.delete();
      start_cyc.delete();
      wr_cnt = 0;
      rd_cnt = 0;
   endtask

   task automatic wait_starts(input int n);
      int ok = 0;
      for (int i = 0; i < 1000 && ok == 0; i++) begin
         @(negedge clk);
         if (tx_q.size() >= n) ok = 1;
      end
      check_eq("start_seen", ok, 1);
   endtask

   task automatic wait_resp(input string tag);
      int ok = 0;
      for (int i = 0; i < 3000 && ok == 0; i++) begin
         @(negedge clk);
         if (!busy && tx_q.size() >= 3) ok = 1;
      end
      check_eq({tag, "_done"}, ok, 1);
   endtask

   task automatic check_resp(input string tag, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] exp [3];
      exp[0] = b0; exp[1] = b1; exp[2] = b2;
      check_eq({tag, "_nbytes"}, tx_q.size(), 3);
      for (int i = 0; i < 3; i++)
         check_eq($sformatf("%s_byte%0d", tag, i), (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hDEAD, {24'h0, exp[i]});
   endtask

   task automatic inject(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_data = 8'hEE;
         rx_done = 1'b1;
      end
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rx_error = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy",     busy,     0);
      check_eq("rst_tx_start", tx_start, 0);
      check_eq("rst_tx_data",  tx_data,  0);
      check_eq("rst_reg_wr",   reg_wr,   0);
      check_eq("rst_reg_rd",   reg_rd,   0);
      check_eq("rst_reg_addr", reg_addr, 0);
      check_eq("rst_drop",     drop_cnt, 0);
      rst = 1'b0;
      @(negedge clk);

      // Write frame
      clear_obs();
      send_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
      check_eq("wr_cnt",  wr_cnt,  1);
      check_eq("wr_addr", wr_addr, 8'h10);
      check_eq("wr_data", wr_data, 8'h3C);
      check_eq("wr_lat",  wr_cyc - rx_cyc, 1);
      wait_resp("wr");
      check_resp("wr", 8'hA5, 8'h00, 8'h3C);
      check_eq("wr_start_lat", (start_cyc.size() > 0) ? start_cyc[0] - rx_cyc : -1, 2);
      check_eq("wr_busy_end", busy, 0);

      // Read frame
      clear_obs();
      send_frame(8'h52, 8'h10, 8'h00, 8'h42);
      wait_resp("rd");
      check_eq("rd_cnt", rd_cnt, 1);
      check_eq("rd_wr_cnt", wr_cnt, 0);
      check_resp("rd", 8'hA5, 8'h00, 8'h3C);
      check_eq("rd_start_lat", (start_cyc.size() > 0) ? start_cyc[0] - rx_cyc : -1, 3);

      // Bad checksum
      clear_obs();
      send_frame(8'h57, 8'h10, 8'h3C, 8'h00);
      wait_resp("chk");
      check_eq("chk_wr_cnt", wr_cnt, 0);
      check_resp("chk", 8'hA5, 8'h01, 8'h00);

      // Unknown command
      clear_obs();
      send_frame(8'h41, 8'h00, 8'h00, 8'h41);
      wait_resp("cmd");
      check_eq("cmd_wr_cnt", wr_cnt, 0);
      check_eq("cmd_rd_cnt", rd_cnt, 0);
      check_resp("cmd", 8'hA5, 8'h02, 8'h00);

      // Inter-byte timeout: still waiting just before, back in IDLE just after
      clear_obs();
      send_byte(8'hA5);
      send_byte(8'h57);
      repeat (88) @(negedge clk);
      check_eq("to_busy_before", busy, 1);
      repeat (20) @(negedge clk);
      check_eq("to_busy_after", busy, 0);
      check_eq("to_no_tx", tx_q.size(), 0);
      send_frame(8'h57, 8'h10, 8'h55, 8'h12);
      wait_resp("to_wr");
      check_eq("to_wr_cnt", wr_cnt, 1);
      check_resp("to_wr", 8'hA5, 8'h00, 8'h55);

      // rx_error mid-frame
      clear_obs();
      send_byte(8'hA5);
      send_byte(8'h57);
      @(negedge clk); rx_error = 1'b1;
      @(negedge clk); rx_error = 1'b0;
      wait_resp("err");
      check_eq("err_wr_cnt", wr_cnt, 0);
      check_resp("err", 8'hA5, 8'h03, 8'h00);

      // Non-SYNC byte in IDLE is neither accepted nor counted
      send_byte(8'h33);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_drop", drop_cnt, 0);

      // Three drops during the response
      clear_obs();
      send_frame(8'h57, 8'h20, 8'h11, 8'h66);
      wait_starts(1);
      inject(3);
      wait_resp("drop3");
      check_eq("drop3_cnt", drop_cnt, 8'h03);
      check_resp("drop3", 8'hA5, 8'h00, 8'h11);

      // Saturation
      clear_obs();
      tx_len = 400;
      send_frame(8'h57, 8'h20, 8'h11, 8'h66);
      wait_starts(1);
      inject(300);
      wait_resp("drop300");
      check_eq("drop300_cnt", drop_cnt, 8'hFF);
      check_resp("drop300", 8'hA5, 8'h00, 8'h11);
      tx_len = 4;

      // Reset between response bytes 1 and 2
      clear_obs();
      send_frame(8'h57, 8'h20, 8'h22, 8'h55);
      wait_starts(2);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("mrst_tx_start", tx_start, 0);
      check_eq("mrst_busy",     busy,     0);
      check_eq("mrst_tx_data",  tx_data,  0);
      check_eq("mrst_drop",     drop_cnt, 0);
      check_eq("mrst_reg_addr", reg_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("mrst_no_more_tx", tx_q.size(), 2);
      check_eq("mrst_idle", busy, 0);

      // Normal frame after reset
      clear_obs();
      send_frame(8'h52, 8'h20, 8'h00, 8'h72);
      wait_resp("post");
      check_eq("post_rd_cnt", rd_cnt, 1);
      check_resp("post", 8'hA5, 8'h00, 8'h22);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
